// File: rtl/arb_pkg.sv
// Shared arbitration definitions used by stream_arb_mux and other arbiters.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED,
    ARB_ROUND_ROBIN
  } arb_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection: fixed priority (lowest index) or round-robin starting after the last grant.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned INPUTS = 8,
  parameter arb_mode_e   MODE   = ARB_ROUND_ROBIN,
  localparam int unsigned SEL_W = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic [INPUTS-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              enable,
  output logic [INPUTS-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic              found;
  int unsigned       pos;
  logic [SEL_W-1:0]  cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    pos       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (MODE == ARB_FIXED) begin
        pos = i;
      end else begin
        // last is always < INPUTS, so one subtraction is enough to wrap
        pos = 32'(last) + i + 1;
        if (pos >= INPUTS) pos = pos - INPUTS;
      end
      cand = SEL_W'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (enable && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// Arbitrating N:1 stream mux with a single registered output stage.
module stream_arb_mux
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned INPUTS = 8,
  parameter arb_mode_e   MODE   = ARB_ROUND_ROBIN,
  localparam int unsigned SEL_W = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [INPUTS-1:0] i_Valid,
  input  logic [WIDTH-1:0]  i_Data [INPUTS],
  output logic [INPUTS-1:0] o_Ready,
  output logic              o_Valid,
  output logic [WIDTH-1:0]  o_Data,
  output logic [SEL_W-1:0]  o_Channel,
  input  logic              i_Ready
);

  logic              load;
  logic              any_valid;
  logic              enable;
  logic [SEL_W-1:0]  last_q;
  logic [SEL_W-1:0]  grant_idx;
  logic [INPUTS-1:0] grant;

  assign load      = !o_Valid || i_Ready;
  assign any_valid = |i_Valid;
  // Reset blocks every input handshake so nothing is lost while the register is cleared
  assign enable    = load && !i_Reset;
  assign o_Ready   = grant;

  rr_arbiter #(
    .INPUTS (INPUTS),
    .MODE   (MODE)
  ) u_arbiter (
    .req       (i_Valid),
    .last      (last_q),
    .enable    (enable),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Valid   <= 1'b0;
      o_Data    <= '0;
      o_Channel <= '0;
      last_q    <= SEL_W'(INPUTS - 1);
    end else if (load) begin
      o_Valid <= any_valid;
      if (any_valid) begin
        o_Data    <= i_Data[grant_idx];
        o_Channel <= grant_idx;
        last_q    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: round-robin, fixed priority and 5-input wrap instances.
module tb_stream_arb_mux;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 8-input round robin
  logic [7:0]  va, rdy_a;
  logic        ra, ov_a;
  logic [31:0] od_a;
  logic [2:0]  oc_a;
  logic [31:0] d8 [8];

  // Instance B: 8-input fixed priority
  logic [7:0]  vb, rdy_b;
  logic        rb, ov_b;
  logic [31:0] od_b;
  logic [2:0]  oc_b;

  // Instance C: 5-input round robin
  logic [4:0]  vc, rdy_c;
  logic        rc, ov_c;
  logic [31:0] od_c;
  logic [2:0]  oc_c;
  logic [31:0] d5 [5];

  stream_arb_mux #(.WIDTH(32), .INPUTS(8), .MODE(ARB_ROUND_ROBIN)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(va), .i_Data(d8), .o_Ready(rdy_a),
    .o_Valid(ov_a), .o_Data(od_a), .o_Channel(oc_a), .i_Ready(ra)
  );

  stream_arb_mux #(.WIDTH(32), .INPUTS(8), .MODE(ARB_FIXED)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(vb), .i_Data(d8), .o_Ready(rdy_b),
    .o_Valid(ov_b), .o_Data(od_b), .o_Channel(oc_b), .i_Ready(rb)
  );

  stream_arb_mux #(.WIDTH(32), .INPUTS(5), .MODE(ARB_ROUND_ROBIN)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(vc), .i_Data(d5), .o_Ready(rdy_c),
    .o_Valid(ov_c), .o_Data(od_c), .o_Channel(oc_c), .i_Ready(rc)
  );

  typedef struct {
    logic [2:0]  ch;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch = 3'(ch);
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic check_word(input string tag, input logic v, input logic [2:0] ch,
                            input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: got word ch=%0d data=%h, expected none queued", tag, ch, d);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, 32'(v), 32'd1);
      chk({tag, ".chan"}, 32'(ch), 32'(e.ch));
      chk({tag, ".data"}, d, e.d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    va  = 8'hff; ra = 1'b1;
    vb  = 8'h00; rb = 1'b1;
    vc  = 5'h00; rc = 1'b1;
    for (int k = 0; k < 8; k++) d8[k] = 32'h100 + 32'(k);
    for (int k = 0; k < 5; k++) d5[k] = 32'h500 + 32'(k);

    // Reset with every channel requesting
    #1 chk("rst.ready_pre", 32'(rdy_a), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.valid", 32'(ov_a), 32'h0);
      chk("rst.data", od_a, 32'h0);
      chk("rst.chan", 32'(oc_a), 32'h0);
      chk("rst.ready", 32'(rdy_a), 32'h0);
    end
    chk("rst.valid_b", 32'(ov_b), 32'h0);
    chk("rst.valid_c", 32'(ov_c), 32'h0);
    rst = 1'b0;

    // Round-robin sweep: 0..7 then 0
    for (int k = 0; k < 8; k++) push(k, 32'h100 + 32'(k));
    push(0, 32'h100);
    #1 chk("sweep.ready_first", 32'(rdy_a), 32'h01);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_word("sweep", ov_a, oc_a, od_a);
    end

    // Backpressure on channel 3
    va = 8'h08;
    #1 chk("bp.ready_load", 32'(rdy_a), 32'h08);
    push(3, 32'h103);
    tick();
    check_word("bp.load", ov_a, oc_a, od_a);
    ra = 1'b0;
    d8[3] = 32'h203;
    #1 chk("bp.ready_stall0", 32'(rdy_a), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp.hold_valid", 32'(ov_a), 32'h1);
      chk("bp.hold_data", od_a, 32'h103);
      chk("bp.hold_chan", 32'(oc_a), 32'h3);
      chk("bp.hold_ready", 32'(rdy_a), 32'h0);
    end
    ra = 1'b1;
    #1 chk("bp.ready_release", 32'(rdy_a), 32'h08);
    push(3, 32'h203);
    tick();
    check_word("bp.next", ov_a, oc_a, od_a);
    va = 8'h00;
    tick();
    chk("idle.valid", 32'(ov_a), 32'h0);
    chk("idle.data_hold", od_a, 32'h203);
    chk("idle.chan_hold", 32'(oc_a), 32'h3);
    d8[3] = 32'h103;

    // Fixed priority: ch2 always beats ch5
    vb = 8'h24;
    #1 chk("fixed.ready_first", 32'(rdy_b), 32'h04);
    for (int i = 0; i < 6; i++) begin
      push(2, 32'h102);
      tick();
      check_word("fixed", ov_b, oc_b, od_b);
      chk("fixed.ready", 32'(rdy_b), 32'h04);
    end
    vb = 8'h00;

    // Five inputs, last=4 from reset: ch1, ch4, ch1
    vc = 5'b10010;
    push(1, 32'h501);
    push(4, 32'h504);
    push(1, 32'h501);
    #1 chk("wrap.ready_first", 32'(rdy_c), 32'h02);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_word("wrap", ov_c, oc_c, od_c);
    end
    vc = 5'h00;

    // Reset while a word is stalled in the output register
    va = 8'h30;
    ra = 1'b0;
    push(4, 32'h104);
    tick();
    check_word("mid.load", ov_a, oc_a, od_a);
    rst = 1'b1;
    #1 chk("mid.ready_in_rst", 32'(rdy_a), 32'h0);
    tick();
    chk("mid.valid", 32'(ov_a), 32'h0);
    chk("mid.data", od_a, 32'h0);
    chk("mid.chan", 32'(oc_a), 32'h0);
    rst = 1'b0;
    ra  = 1'b1;
    #1 chk("mid.ready_first", 32'(rdy_a), 32'h10);
    push(4, 32'h104);
    push(5, 32'h105);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_word("mid.after", ov_a, oc_a, od_a);
    end
    va = 8'h00;

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
